// File: rtl/spi_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_responder : SPI mode-0 target; decodes read/write command frames and
//                 serves or captures one byte through a register-bank port.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module spi_responder #(
  parameter logic [7:0] RD_CMD = 8'h0B,
  parameter logic [7:0] WR_CMD = 8'h02,
  parameter int         RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs,
  input  logic       MOSI,
  output logic       MISO,
  output logic [7:0] addr,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_R, RD_WAIT, RD_DATA, ADDR_W, WR_DATA, IGNORE
  } state_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  logic       sclk_meta, sclk_sync, sclk_prev;
  logic       cs_meta, cs_sync;
  logic       mosi_meta, mosi_sync, mosi_dly;
  logic       rise, fall;

  state_t     state, state_next;
  logic       armed;
  logic [2:0] cnt;
  logic [1:0] wait_cnt;
  logic       tx_done;
  logic [7:0] shift_in, shift_out;
  logic [7:0] byte_in;
  logic       last_rise;
  logic       rd_fire, wr_fire, err_fire, addr_fire;

  // Synchronizer chains carry no reset so a frame in flight stays visible across rst.
  always_ff @(posedge clk) begin
    sclk_meta <= sclk;
    sclk_sync <= sclk_meta;
    sclk_prev <= sclk_sync;
    cs_meta   <= cs;
    cs_sync   <= cs_meta;
    mosi_meta <= MOSI;
    mosi_sync <= mosi_meta;
    mosi_dly  <= mosi_sync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
      busy <= 1'b0;
    end else begin
      rise <= sclk_sync & ~sclk_prev;
      fall <= ~sclk_sync & sclk_prev;
      busy <= ~cs_sync;
    end
  end

  assign byte_in   = {shift_in[6:0], mosi_dly};
  assign last_rise = rise && (cnt == 3'd7);

  always_comb begin
    state_next = state;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    err_fire   = 1'b0;
    addr_fire  = 1'b0;
    case (state)
      IDLE:    if (!cs_sync && armed) state_next = CMD;
      CMD: begin
        if (last_rise) begin
          if (byte_in == RD_CMD)      state_next = ADDR_R;
          else if (byte_in == WR_CMD) state_next = ADDR_W;
          else begin
            state_next = IGNORE;
            err_fire   = 1'b1;
          end
        end
      end
      ADDR_R: begin
        if (last_rise) begin
          state_next = RD_WAIT;
          rd_fire    = 1'b1;
          addr_fire  = 1'b1;
        end
      end
      RD_WAIT: if (wait_cnt == LAT) state_next = RD_DATA;
      // Bit 0 must stay on MISO until the controller's final rise, so leave on the 9th fall.
      RD_DATA: if (fall && tx_done) state_next = IGNORE;
      ADDR_W: begin
        if (last_rise) begin
          state_next = WR_DATA;
          addr_fire  = 1'b1;
        end
      end
      WR_DATA: begin
        if (last_rise) begin
          state_next = IGNORE;
          wr_fire    = 1'b1;
        end
      end
      default: state_next = state;
    endcase
    if (cs_sync) begin
      state_next = IDLE;
      rd_fire    = 1'b0;
      wr_fire    = 1'b0;
      err_fire   = 1'b0;
      addr_fire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      cnt       <= 3'd0;
      wait_cnt  <= 2'd0;
      tx_done   <= 1'b0;
      shift_in  <= 8'h00;
      shift_out <= 8'hFF;
      addr      <= 8'h00;
      wr_data   <= 8'h00;
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      cmd_err   <= 1'b0;
      MISO      <= 1'b1;
    end else begin
      state   <= state_next;
      rd_en   <= rd_fire;
      wr_en   <= wr_fire;
      cmd_err <= err_fire;
      if (cs_sync)   armed   <= 1'b1;
      if (addr_fire) addr    <= byte_in;
      if (wr_fire)   wr_data <= byte_in;
      if (cs_sync || state == IDLE) begin
        cnt      <= 3'd0;
        wait_cnt <= 2'd0;
        tx_done  <= 1'b0;
        MISO     <= 1'b1;
      end else begin
        case (state)
          CMD, ADDR_R, ADDR_W, WR_DATA: begin
            if (rise) begin
              shift_in <= byte_in;
              cnt      <= cnt + 3'd1;
            end
          end
          RD_WAIT: begin
            wait_cnt <= wait_cnt + 2'd1;
            // At the minimum clock ratio the first data fall can coincide with the load.
            if (wait_cnt == LAT) begin
              if (fall) begin
                MISO      <= rd_data[7];
                shift_out <= {rd_data[6:0], 1'b1};
                cnt       <= 3'd1;
              end else begin
                shift_out <= rd_data;
              end
            end
          end
          RD_DATA: begin
            if (fall) begin
              if (tx_done) begin
                MISO <= 1'b1;
              end else begin
                MISO      <= shift_out[7];
                shift_out <= {shift_out[6:0], 1'b1};
                cnt       <= cnt + 3'd1;
                if (cnt == 3'd7) tx_done <= 1'b1;
              end
            end
          end
          default: MISO <= 1'b1;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
